// File: rtl/updown_counter_param.sv
// Parametrised up/down modulo counter with load, wrap/saturate mode,
// registered overflow/underflow pulses and a cascadable terminal count.
module updown_counter_param #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_down,
    output logic [WIDTH-1:0] counter,
    output logic             tc,
    output logic             ovf,
    output logic             unf,
    output logic             at_zero
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic at_max;

    assign at_max  = (counter == MAX_V);
    assign at_zero = (counter == '0);
    // Goes high the cycle before a boundary step so the next digit can use it as en.
    assign tc      = en & ~load & ((~up_down & at_max) | (up_down & at_zero));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter <= '0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
        end else begin
            ovf <= 1'b0;
            unf <= 1'b0;
            if (load) begin
                counter <= (load_val > MAX_V) ? MAX_V : load_val;
            end else if (en) begin
                if (!up_down) begin
                    if (at_max) begin
                        ovf <= 1'b1;
                        if (!SATURATE) counter <= '0;
                    end else begin
                        counter <= counter + ONE;
                    end
                end else begin
                    if (at_zero) begin
                        unf <= 1'b1;
                        if (!SATURATE) counter <= MAX_V;
                    end else begin
                        counter <= counter - ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: three configurations driven in lockstep,
// a reference model feeds an expected queue that a monitor drains each cycle.
module tb_updown_counter_param;

    logic       clk;
    logic       reset;
    logic       en;
    logic       load;
    logic [3:0] load_val;
    logic       up_down;

    logic [3:0] c0, c1;
    logic [2:0] c2;
    logic       tc0, tc1, tc2, ovf0, ovf1, ovf2, unf0, unf1, unf2, az0, az1, az2;

    // d0: decade wrap, d1: full 4-bit saturate, d2: 3-bit modulo-6 saturate
    updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) d0 (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
        .up_down(up_down), .counter(c0), .tc(tc0), .ovf(ovf0), .unf(unf0), .at_zero(az0));
    updown_counter_param #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1'b1)) d1 (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
        .up_down(up_down), .counter(c1), .tc(tc1), .ovf(ovf1), .unf(unf1), .at_zero(az1));
    updown_counter_param #(.WIDTH(3), .MAX_VAL(5), .SATURATE(1'b1)) d2 (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val[2:0]),
        .up_down(up_down), .counter(c2), .tc(tc2), .ovf(ovf2), .unf(unf2), .at_zero(az2));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state, one entry per instance
    int maxv[3]  = '{9, 15, 5};
    int sat[3]   = '{0, 1, 1};
    int wmask[3] = '{15, 15, 7};
    int mc[3]    = '{0, 0, 0};

    // each entry: three 8-bit packets {counter, ovf, unf, tc, at_zero}
    logic [23:0] exp_q[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got cnt=%0d ovf=%b unf=%b tc=%b az=%b, want cnt=%0d ovf=%b unf=%b tc=%b az=%b",
                     name, $time, act[7:4], act[3], act[2], act[1], act[0],
                     exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [23:0] actual();
        return {c0, ovf0, unf0, tc0, az0,
                c1, ovf1, unf1, tc1, az1,
                {1'b0, c2}, ovf2, unf2, tc2, az2};
    endfunction

    function automatic logic [7:0] model_step(input int i, input logic e, input logic l,
                                              input logic [3:0] lv, input logic ud);
        int  v;
        logic o, u, t, z;
        v = int'(lv) & wmask[i];
        o = 1'b0;
        u = 1'b0;
        if (l) begin
            mc[i] = (v > maxv[i]) ? maxv[i] : v;
        end else if (e && !ud) begin
            if (mc[i] == maxv[i]) begin
                o = 1'b1;
                if (sat[i] == 0) mc[i] = 0;
            end else mc[i] = mc[i] + 1;
        end else if (e && ud) begin
            if (mc[i] == 0) begin
                u = 1'b1;
                if (sat[i] == 0) mc[i] = maxv[i];
            end else mc[i] = mc[i] - 1;
        end
        t = e && !l && ((!ud && mc[i] == maxv[i]) || (ud && mc[i] == 0));
        z = (mc[i] == 0);
        return {4'(mc[i]), o, u, t, z};
    endfunction

    // driver: apply one cycle of inputs and push the expected post-edge view
    task automatic step(input logic e, input logic l, input logic [3:0] lv, input logic ud);
        logic [23:0] exp;
        @(negedge clk);
        en = e; load = l; load_val = lv; up_down = ud;
        exp[23:16] = model_step(0, e, l, lv, ud);
        exp[15:8]  = model_step(1, e, l, lv, ud);
        exp[7:0]   = model_step(2, e, l, lv, ud);
        exp_q.push_back(exp);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0; en = 1'b0; load = 1'b0; up_down = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) mc[i] = 0;
    endtask

    task automatic count(input int n, input logic ud);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 4'd0, ud);
    endtask

    // monitor / scoreboard
    initial begin
        logic [23:0] exp, act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                act = actual();
                check("d0_dec_wrap", act[23:16], exp[23:16]);
                check("d1_hex_sat",  act[15:8],  exp[15:8]);
                check("d2_mod6_sat", act[7:0],   exp[7:0]);
            end
        end
    end

    initial begin
        reset = 1'b0; en = 1'b0; load = 1'b0; load_val = 4'd0; up_down = 1'b0;
        #12;
        check("reset_d0", {c0, ovf0, unf0, tc0, az0}, 8'b0000_0001);
        check("reset_d1", {c1, ovf1, unf1, tc1, az1}, 8'b0000_0001);
        check("reset_d2", {1'b0, c2, ovf2, unf2, tc2, az2}, 8'b0000_0001);
        @(negedge clk);
        reset = 1'b1;

        // up through the decade boundary, then down from reset
        count(12, 1'b0);
        apply_reset();
        count(3, 1'b1);

        // saturate at top and bottom
        step(1'b0, 1'b1, 4'd14, 1'b0);
        count(4, 1'b0);
        step(1'b0, 1'b1, 4'd1, 1'b0);
        count(2, 1'b1);

        // load beats en; out-of-range load clamps
        step(1'b1, 1'b1, 4'd12, 1'b1);
        step(1'b1, 1'b1, 4'd5, 1'b0);

        // direction flip then hold
        apply_reset();
        count(5, 1'b0);
        step(1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 1'b1);
        step(1'b1, 1'b0, 4'd0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)));

        // asynchronous reset between edges mid-count
        count(1, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b0; en = 1'b0; load = 1'b0; up_down = 1'b0;
        #1;
        check("async_rst_d0", {c0, ovf0, unf0, tc0, az0}, 8'b0000_0001);
        check("async_rst_d1", {c1, ovf1, unf1, tc1, az1}, 8'b0000_0001);
        check("async_rst_d2", {1'b0, c2, ovf2, unf2, tc2, az2}, 8'b0000_0001);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) mc[i] = 0;
        count(3, 1'b0);

        // randomized traffic
        for (int k = 0; k < 500; k++) begin
            step($urandom_range(3, 0) != 0, $urandom_range(7, 0) == 0,
                 4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)));
        end

        @(posedge clk);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
Parametrised successor to the fixed 4-bit T-flip-flop up/down counter. Adds:
- Configurable width and terminal value (modulus), e.g. decade counters.
- Count enable and synchronous parallel load.
- Selectable wrap or saturate mode.
- Registered overflow/underflow pulses and a combinational terminal-count output for cascading stages into multi-digit counters.

Parameters:
WIDTH, 4, counter width in bits (≥1).
MAX_VAL, 2**WIDTH-1, highest count value; range is 0..MAX_VAL; must satisfy 1 ≤ MAX_VAL ≤ 2**WIDTH-1.
SATURATE, 0, 0 = wrap at boundaries, 1 = hold at boundaries.

Ports:
clk        input   1      clock; all state updates on rising edge.
reset      input   1      asynchronous, active-low reset.
en         input   1      count enable.
load       input   1      synchronous load strobe.
load_val   input   WIDTH  value captured when load=1.
up_down    input   1      direction: 0 = count up, 1 = count down.
counter    output  WIDTH  current count (registered).
tc         output  1      terminal count (combinational).
ovf        output  1      one-cycle pulse: up-count attempted past MAX_VAL (registered).
unf        output  1      one-cycle pulse: down-count attempted below 0 (registered).
at_zero    output  1      counter == 0 (combinational from register).

Behaviour:
- Reset (reset=0, any time, asynchronous): counter=0, ovf=0, unf=0. Outputs after reset: at_zero=1, tc=0 (while en=0).
- On release, the counter resumes on the first rising clk edge that sees reset=1. No synchronizer is inside the block.
- Priority per rising edge: load > en > hold.
- Load:
  - counter <= load_val; if load_val > MAX_VAL, counter <= MAX_VAL (clamp).
  - ovf/unf <= 0.
  - en and up_down are ignored that cycle.
- Enabled count (en=1, load=0), up_down=0:
  - counter < MAX_VAL: counter+1.
  - counter == MAX_VAL: counter <= 0 if SATURATE=0, else holds MAX_VAL. ovf <= 1 in both modes.
- Enabled count (en=1, load=0), up_down=1:
  - counter > 0: counter-1.
  - counter == 0: counter <= MAX_VAL if SATURATE=0, else holds 0. unf <= 1 in both modes.
- Hold (en=0, load=0): counter unchanged; ovf/unf <= 0.
- ovf and unf are high for exactly one cycle per boundary event and are never high simultaneously. Under continuous en at a boundary in saturate mode, ovf/unf stay high every cycle (one pulse per attempted step).
- tc = en & ~load & ((~up_down & counter==MAX_VAL) | (up_down & counter==0)). It is high in the cycle before the boundary event, so the next stage's en can be driven directly by tc.
- up_down may change on any cycle; it takes effect on the next edge, with no turnaround delay.
- Latency: counter reflects load or step one cycle after the sampling edge. ovf/unf assert on the same edge as the wrap.
- Arithmetic is modular within WIDTH bits. counter never exceeds MAX_VAL after reset or any load.
- Internal structure (T flip-flops or behavioral register) is free, provided cycle behaviour matches.

Test Plan:
1. WIDTH=4, MAX_VAL=9, SATURATE=0: reset, en=1, up_down=0 for 12 cycles -> counter 1..9,0,1,2; ovf pulses once on the 9->0 edge; tc high while counter=9.
2. Same config, up_down=1 from reset for 3 cycles -> counter 9,8,7; unf pulses on the 0->9 edge; tc high in cycle with counter=0.
3. WIDTH=4, MAX_VAL=15, SATURATE=1: load 14, en=1 up for 4 cycles -> counter 15,15,15,15; ovf high on cycles 2-4; then down from 1 -> 0,0 with unf on the second edge.
4. load=1 with en=1, load_val=12, MAX_VAL=9 -> counter=9 next cycle; ovf=unf=0. Then load_val=5 -> counter=5.
5. Direction flip: count up to 5, toggle up_down=1 for one cycle, then back to 0 -> 6,5,6. en=0 for 3 cycles -> counter holds 6, ovf=unf=tc=0.
6. Assert reset low mid-count (counter=7), asynchronously between edges -> counter=0 immediately without waiting for clk, ovf=unf=0, at_zero=1. Release -> counting resumes from 0 on the next edge.
